sdram_wr_arbiter: RTL

//  Shares the single sdram_top user write port (wr_en/wr_data, wr_clk domain) between two requesters.

---
 rtl/sdram_arb_pkg.sv | 19 +
 rtl/sdram_wr_arbiter_if.sv | 35 +++
 rtl/sdram_arb_pick.sv | 29 ++
 rtl/sdram_wr_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types, grant constants and the burst-length compare for the SDRAM write arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

  // True when the beat counter sits on the final beat of a burst.
  function automatic logic last_beat(input logic [31:0] cnt, input logic [31:0] burst_len);
    return cnt == (burst_len - 32'd1);
  endfunction

endpackage

// File: rtl/sdram_wr_arbiter_if.sv
// Requester-side handshakes and the write-FIFO port of the SDRAM write arbiter.
interface sdram_wr_arbiter_if #(
  parameter int unsigned DATA_W = 64
);
  logic              req0_req;
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req0_done;

  logic              req1_req;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              req1_done;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        grant;
  logic              abort;

  modport master (
    output req0_req, req0_valid, req0_data,
    output req1_req, req1_valid, req1_data,
    input  req0_ready, req0_done, req1_ready, req1_done,
    input  wr_en, wr_data, grant, abort
  );

  modport slave (
    input  req0_req, req0_valid, req0_data,
    input  req1_req, req1_valid, req1_data,
    output req0_ready, req0_done, req1_ready, req1_done,
    output wr_en, wr_data, grant, abort
  );
endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational 2-way picker; round-robin by default, fixed priority to req0
// when SDRAM_ARB_FIXED_PRIO_EN is defined.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] pick
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  logic unused_rr_last;
  assign unused_rr_last = rr_last;

  always_comb begin
    pick = GNT_NONE;
    if (req[0])      pick = GNT_0;
    else if (req[1]) pick = GNT_1;
  end
`else
  always_comb begin
    pick = GNT_NONE;
    if (&req)        pick = rr_last ? GNT_0 : GNT_1;
    else if (req[0]) pick = GNT_0;
    else if (req[1]) pick = GNT_1;
  end
`endif

endmodule

// File: rtl/sdram_wr_arbiter.sv
// Burst-granting arbiter sharing the sdram_top write port between two requesters.
// Arbitration mode selected by SDRAM_ARB_FIXED_PRIO_EN (see sdram_arb_pick).
module sdram_wr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BURST_LEN = 256,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             sdram_init_done,
  sdram_wr_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        gap_q, gap_d;
  logic              rr_last_q, rr_last_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        done_q, done_d;
  logic              abort_q, abort_d;

  logic [1:0]        pick;
  logic [1:0]        ready;
  logic              own_req, own_valid, accept;
  logic [DATA_W-1:0] own_data;

  sdram_arb_pick u_pick (
    .req     ({bus.req1_req, bus.req0_req}),
    .rr_last (rr_last_q),
    .pick    (pick)
  );

  assign ready     = (state_q == ST_BURST) ? grant_q : GNT_NONE;
  assign own_req   = grant_q[1] ? bus.req1_req   : bus.req0_req;
  assign own_valid = grant_q[1] ? bus.req1_valid : bus.req0_valid;
  assign own_data  = grant_q[1] ? bus.req1_data  : bus.req0_data;
  assign accept    = own_valid && (|ready);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    rr_last_d = rr_last_q;
    wr_en_d   = accept;
    wr_data_d = accept ? own_data : wr_data_q;
    done_d    = '0;
    abort_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sdram_init_done && (bus.req0_req || bus.req1_req)) begin
          grant_d   = pick;
          rr_last_d = pick[1];
          cnt_d     = '0;
          state_d   = ST_BURST;
        end
      end

      ST_BURST: begin
        // Completion outranks a same-cycle req drop; an accepted beat is always written.
        if (!sdram_init_done) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (accept && last_beat(32'(cnt_q), BURST_LEN)) begin
          done_d  = grant_q;
          grant_d = GNT_NONE;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (!own_req) begin
          abort_d = 1'b1;
          grant_d = GNT_NONE;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (!sdram_init_done || (gap_q == 4'(GAP_CYC - 1))) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
        cnt_d   = '0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= GNT_NONE;
      cnt_q     <= '0;
      gap_q     <= '0;
      rr_last_q <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      rr_last_q <= rr_last_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.req0_done  = done_q[0];
  assign bus.req1_done  = done_q[1];
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.grant      = grant_q;
  assign bus.abort      = abort_q;

endmodule
